icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage (`if_`) and the memory controller (`mem_ctrl`). It returns a hit one cycle after the request. On a miss it issues a single word refill to `mem_ctrl`, installs the word and returns it. This removes the 4-byte serial fetch from every instruction on the cache-hit path.

---
 rtl/icache.sv | 137 +++++++++++++
 tb/tb_icache.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with single-word refill; optional ICACHE_STATS_EN adds hit/miss counters
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_done,
  output logic        fill_req,
  output logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic        fill_done
);
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic {IDLE, FILL} state_t;
  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:0]           inst_q, inst_d, inst_addr_q, inst_addr_d, fill_addr_q, fill_addr_d;
  logic                  inst_done_q, inst_done_d, fill_req_q, fill_req_d, abort_q, abort_d;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit, wr_en;
  assign req_idx  = req_addr[1+INDEX_BITS:2];
  assign req_tag  = req_addr[17:2+INDEX_BITS];
  assign fill_idx = fill_addr_q[1+INDEX_BITS:2];
  assign fill_tag = fill_addr_q[17:2+INDEX_BITS];
  // I/O region never hits, even if a stale tag were to match
  assign hit = valid_q[req_idx] && tag_q[req_idx] == req_tag && req_addr[17:16] != 2'b11;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign inst_done   = inst_done_q;
  assign fill_req    = fill_req_q;
  assign fill_addr   = fill_addr_q;
  // next-state: hit response in IDLE, refill sequencing and abort tracking in FILL
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    inst_done_d = 1'b0;
    fill_req_d  = fill_req_q;
    fill_addr_d = fill_addr_q;
    abort_d     = abort_q;
    wr_en       = 1'b0;
    if (state_q == IDLE) begin
      if (req_valid && !flush) begin
        if (hit) begin
          inst_done_d = 1'b1;
          inst_d      = data_q[req_idx];
          inst_addr_d = req_addr;
        end else begin
          state_d     = FILL;
          fill_req_d  = 1'b1;
          fill_addr_d = req_addr;
          abort_d     = 1'b0;
        end
      end
    end else begin
      abort_d = abort_q | flush;
      if (fill_done) begin
        state_d    = IDLE;
        fill_req_d = 1'b0;
        wr_en      = fill_addr_q[17:16] != 2'b11;
        if (!abort_q && !flush) begin
          inst_done_d = 1'b1;
          inst_d      = fill_data;
          inst_addr_d = fill_addr_q;
        end
      end
    end
    if (wr_en) valid_d[fill_idx] = 1'b1;
  end
  // control and output registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      inst_done_q <= 1'b0;
      fill_req_q  <= 1'b0;
      fill_addr_q <= '0;
      abort_q     <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      inst_done_q <= inst_done_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
      abort_q     <= abort_d;
    end
  end
  // tag/data arrays need no reset: valid gates every use
  always_ff @(posedge clk) begin
    if (!rst && rdy && wr_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        hit_inc, miss_inc;
  assign hit_inc  = state_q == IDLE && req_valid && !flush && hit;
  assign miss_inc = state_q == IDLE && req_valid && !flush && !hit;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  // counters: hits on IDLE responses, misses on every FILL entry
  always_comb begin
    hit_cnt_d  = hit_inc ? hit_cnt_q + 32'd1 : hit_cnt_q;
    miss_cnt_d = miss_inc ? miss_cnt_q + 32'd1 : miss_cnt_q;
  end
  // counter registers, gated by rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed test-plan scenarios plus randomized IF/mem_ctrl traffic against a transaction-level cache model
module tb_icache;
  localparam int IB = 7;
  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, flush = 1'b0, req_valid = 1'b0, fill_done = 1'b0;
  logic [31:0] req_addr = '0, fill_data = '0;
  logic [31:0] inst_o, inst_addr_o, fill_addr;
  logic        inst_done, fill_req;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int tests = 0, fails = 0;
  // reference model: cache contents as sparse maps, refill as a pending flag
  bit          m_valid [int];
  logic [31:0] m_tag [int];
  logic [31:0] m_data [int];
  bit          m_pend = 0, m_abort = 0, e_done = 0;
  logic [31:0] e_inst = '0, e_iaddr = '0, e_faddr = '0, m_hits = '0, m_miss = '0;
  int          mc_wait = 0;

  icache #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_done(inst_done), .fill_req(fill_req),
    .fill_addr(fill_addr), .fill_data(fill_data),
`ifdef ICACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << IB) - 1));
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return (a >> (2 + IB)) & ((32'd1 << (16 - IB)) - 1);
  endfunction
  function automatic bit cacheable(input logic [31:0] a);
    return ((a >> 16) & 32'd3) != 32'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model by the inputs the DUT just sampled
  task automatic model_update();
    int i;
    if (rst) begin
      m_valid.delete();
      m_pend = 0; m_abort = 0; e_done = 0;
      e_inst = '0; e_iaddr = '0; e_faddr = '0; m_hits = '0; m_miss = '0;
    end else if (rdy) begin
      e_done = 0;
      if (!m_pend) begin
        if (req_valid && !flush) begin
          i = idx_of(req_addr);
          if (cacheable(req_addr) && m_valid.exists(i) && m_tag[i] == tag_of(req_addr)) begin
            e_done = 1; e_inst = m_data[i]; e_iaddr = req_addr; m_hits++;
          end else begin
            m_pend = 1; m_abort = 0; e_faddr = req_addr; m_miss++;
          end
        end
      end else begin
        if (flush) m_abort = 1;
        if (fill_done) begin
          if (cacheable(e_faddr)) begin
            i = idx_of(e_faddr);
            m_valid[i] = 1; m_tag[i] = tag_of(e_faddr); m_data[i] = fill_data;
          end
          if (!m_abort) begin
            e_done = 1; e_inst = fill_data; e_iaddr = e_faddr;
          end
          m_pend = 0;
        end
      end
    end
  endtask

  // one clock: update model, compare every output
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("inst_done", {31'd0, inst_done}, {31'd0, e_done});
    chk("inst_o", inst_o, e_inst);
    chk("inst_addr_o", inst_addr_o, e_iaddr);
    chk("fill_req", {31'd0, fill_req}, {31'd0, m_pend});
    chk("fill_addr", fill_addr, e_faddr);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  task automatic do_miss(input logic [31:0] a, input int lat, input logic [31:0] d);
    req_valid = 1; req_addr = a;
    step();
    chk("miss_fill_req", {31'd0, fill_req}, 32'd1);
    chk("miss_fill_addr", fill_addr, a);
    repeat (lat - 1) begin
      step();
      chk("miss_fill_req_held", {31'd0, fill_req}, 32'd1);
    end
    fill_done = 1; fill_data = d;
    step();
    fill_done = 0;
    chk("miss_fill_req_drop", {31'd0, fill_req}, 32'd0);
    chk("miss_done", {31'd0, inst_done}, 32'd1);
    chk("miss_data", inst_o, d);
    chk("miss_addr", inst_addr_o, a);
    req_valid = 0;
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_addr = a;
    step();
    chk("hit_done", {31'd0, inst_done}, 32'd1);
    chk("hit_data", inst_o, d);
    chk("hit_no_fill", {31'd0, fill_req}, 32'd0);
    req_valid = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 3) << 2) | ($urandom_range(0, 2) << (2 + IB));
    if ($urandom_range(0, 7) == 0) a = a | 32'h0003_0000;
    return a;
  endfunction

  initial begin
    step();
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_done", {31'd0, inst_done}, 32'd0);
    chk("rst_fill_req", {31'd0, fill_req}, 32'd0);
    chk("rst_fill_addr", fill_addr, 32'h0);
    rst = 0;
    step();
    do_miss(32'h0, 3, 32'h0000_0513);
    do_hit(32'h0, 32'h0000_0513);
`ifdef ICACHE_STATS_EN
    chk("stats_hit1", hit_cnt, 32'd1);
    chk("stats_miss1", miss_cnt, 32'd1);
`endif
    step();
    do_miss(32'h4, 2, 32'h1111_1111);
    do_miss(32'h204, 2, 32'h2222_2222);
    do_miss(32'h4, 1, 32'h3333_3333);
    req_valid = 1; req_addr = 32'h10;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    step();
    fill_done = 1; fill_data = 32'h4444_4444;
    step();
    fill_done = 0;
    chk("abort_no_done", {31'd0, inst_done}, 32'd0);
    do_hit(32'h10, 32'h4444_4444);
    do_miss(32'h0003_0000, 2, 32'h5555_5555);
    do_miss(32'h0003_0000, 2, 32'h5555_5556);
    req_valid = 1; req_addr = 32'h80;
    step();
    req_valid = 0; fill_done = 1; flush = 1; fill_data = 32'h6666_6666;
    step();
    fill_done = 0; flush = 0;
    chk("flush_fd_no_done", {31'd0, inst_done}, 32'd0);
    do_hit(32'h80, 32'h6666_6666);
    req_valid = 1; req_addr = 32'h40;
    step();
    rdy = 0;
    repeat (5) begin
      step();
      chk("rdy_hold_fill_req", {31'd0, fill_req}, 32'd1);
      chk("rdy_no_done", {31'd0, inst_done}, 32'd0);
    end
    rdy = 1;
    step();
    fill_done = 1; fill_data = 32'h0000_0513;
    step();
    fill_done = 0; req_valid = 0;
    chk("rdy_done", {31'd0, inst_done}, 32'd1);
    chk("rdy_data", inst_o, 32'h0000_0513);
    req_valid = 1; req_addr = 32'h40;
    step();
    req_valid = 0; rdy = 0;
    step();
    chk("rdy_done_held", {31'd0, inst_done}, 32'd1);
    rdy = 1;
    step();
    chk("done_pulse_end", {31'd0, inst_done}, 32'd0);
    req_valid = 1; req_addr = 32'hC0;
    step();
    req_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_in_fill", {31'd0, fill_req}, 32'd0);
    do_miss(32'h0, 1, 32'h7777_7777);
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      rdy = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 11) == 0;
      fill_done = 0;
      if (e_done || !req_valid || $urandom_range(0, 19) == 0) begin
        req_valid = $urandom_range(0, 4) != 0;
        req_addr = rand_addr();
      end
      if (rdy && m_pend) begin
        if (mc_wait == 0) begin
          fill_done = 1; fill_data = $urandom; mc_wait = $urandom_range(0, 3);
        end else mc_wait--;
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
